// File: rtl/stream_frame_packer.sv
// -----------------------------------------------------------------------------
// stream_frame_packer
//   Collects the gapped merged data stream per event into a word FIFO and emits
//   one frame per closed event on a ready/valid link:
//   header {BX, count}, the event's data words, then trailer {truncated, count}.
//
// Ports
//   clk        processing clock
//   reset      asynchronous, active-high reset
//   new_event  one-cycle pulse: close the open event, open the next one
//   BX         bunch crossing of the event opened by new_event
//   in_dat     merged data word
//   in_valid   in_dat holds a valid word this cycle (no upstream backpressure)
//   out_dat    frame word
//   out_kind   00 idle, 01 header, 10 data, 11 trailer
//   out_valid  out_dat/out_kind valid
//   out_ready  downstream accepts the word when out_valid & out_ready
//   overflow   sticky: a word or a whole event was dropped since reset
// -----------------------------------------------------------------------------
module stream_frame_packer #(
    parameter int DW         = 45,
    parameter int FIFO_AW    = 6,
    parameter int DESC_DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          new_event,
    input  logic [2:0]    BX,
    input  logic [DW-1:0] in_dat,
    input  logic          in_valid,
    output logic [DW-1:0] out_dat,
    output logic [1:0]    out_kind,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          overflow
);

    localparam int DESC_AW = $clog2(DESC_DEPTH);
    localparam logic [FIFO_AW:0] FIFO_FULL = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [DESC_AW:0] DESC_FULL = {1'b1, {DESC_AW{1'b0}}};
    localparam logic [1:0] KIND_IDLE = 2'b00;
    localparam logic [1:0] KIND_HDR  = 2'b01;
    localparam logic [1:0] KIND_DATA = 2'b10;
    localparam logic [1:0] KIND_TRL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEADER  = 2'd1,
        ST_DATA    = 2'd2,
        ST_TRAILER = 2'd3
    } state_t;

    typedef struct packed {
        logic [2:0] bx;
        logic [5:0] cnt;
        logic       trunc;
    } desc_t;

    function automatic logic [DW-1:0] hdr_word(input logic [2:0] bx, input logic [5:0] cnt);
        logic [DW-1:0] w;
        w = '0;
        w[DW-1 -: 3] = bx;
        w[5:0] = cnt;
        return w;
    endfunction

    function automatic logic [DW-1:0] trl_word(input logic trunc, input logic [5:0] cnt);
        logic [DW-1:0] w;
        w = '0;
        w[DW-1] = trunc;
        w[5:0] = cnt;
        return w;
    endfunction

    // Open-event bookkeeping; open_q is set only for an admitted event, so it
    // doubles as the descriptor slot reserved for that event.
    logic          open_q, open_d;
    logic [2:0]    bx_q, bx_d;
    logic [5:0]    wcnt_q, wcnt_d;
    logic          trunc_q, trunc_d;
    logic          overflow_q, overflow_d;

    logic [DW-1:0]      fifo_mem [1 << FIFO_AW];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   fifo_cnt_q, fifo_cnt_d;

    desc_t              desc_mem [DESC_DEPTH];
    logic [DESC_AW-1:0] desc_wr_q, desc_wr_d, desc_rd_q, desc_rd_d;
    logic [DESC_AW:0]   desc_cnt_q, desc_cnt_d;

    state_t        state_q;
    logic [DW-1:0] out_dat_q;
    logic [1:0]    out_kind_q;
    logic          out_valid_q;
    logic [5:0]    remain_q;

    logic          fifo_full_s, fifo_push_s, fifo_pop_s, word_drop_s;
    logic          desc_push_s, desc_pop_s, admit_s, skip_s, xfer_s;
    logic [5:0]    wcnt_upd_s;
    logic          trunc_upd_s;
    desc_t         head_s, next_s, new_desc_s;

    // Input side: word acceptance, event open/close and admission.
    always_comb begin
        fifo_full_s = (fifo_cnt_q == FIFO_FULL);
        fifo_push_s = open_q & in_valid & ~fifo_full_s & (wcnt_q != 6'd63);
        word_drop_s = open_q & in_valid & ~fifo_push_s;
        // A word arriving together with new_event still belongs to the closing event.
        wcnt_upd_s  = wcnt_q + {5'd0, fifo_push_s};
        trunc_upd_s = trunc_q | word_drop_s;
        desc_push_s = new_event & open_q;
        new_desc_s  = '{bx: bx_q, cnt: wcnt_upd_s, trunc: trunc_upd_s};
        // Room must remain for the closing event's descriptor plus this one.
        admit_s     = new_event & ((desc_cnt_q + {{DESC_AW{1'b0}}, open_q}) < DESC_FULL);
        skip_s      = new_event & ~admit_s;
        if (new_event) begin
            open_d  = admit_s;
            bx_d    = BX;
            wcnt_d  = 6'd0;
            trunc_d = 1'b0;
        end else begin
            open_d  = open_q;
            bx_d    = bx_q;
            wcnt_d  = wcnt_upd_s;
            trunc_d = trunc_upd_s;
        end
        overflow_d = overflow_q | word_drop_s | skip_s;
    end

    // Output side: which queue entries the FSM consumes this cycle.
    always_comb begin
        xfer_s     = out_valid_q & out_ready;
        head_s     = desc_mem[desc_rd_q];
        next_s     = desc_mem[desc_rd_q + {{(DESC_AW-1){1'b0}}, 1'b1}];
        fifo_pop_s = 1'b0;
        desc_pop_s = 1'b0;
        case (state_q)
            ST_HEADER:  fifo_pop_s = xfer_s & (head_s.cnt != 6'd0);
            ST_DATA:    fifo_pop_s = xfer_s & (remain_q != 6'd0);
            ST_TRAILER: desc_pop_s = xfer_s;
            default: begin
                fifo_pop_s = 1'b0;
                desc_pop_s = 1'b0;
            end
        endcase
    end

    // Queue pointer and occupancy next-state; a write at full is simply not issued.
    always_comb begin
        wr_ptr_d   = wr_ptr_q + {{(FIFO_AW-1){1'b0}}, fifo_push_s};
        rd_ptr_d   = rd_ptr_q + {{(FIFO_AW-1){1'b0}}, fifo_pop_s};
        fifo_cnt_d = fifo_cnt_q + {{FIFO_AW{1'b0}}, fifo_push_s} - {{FIFO_AW{1'b0}}, fifo_pop_s};
        desc_wr_d  = desc_wr_q + {{(DESC_AW-1){1'b0}}, desc_push_s};
        desc_rd_d  = desc_rd_q + {{(DESC_AW-1){1'b0}}, desc_pop_s};
        desc_cnt_d = desc_cnt_q + {{DESC_AW{1'b0}}, desc_push_s} - {{DESC_AW{1'b0}}, desc_pop_s};
    end

    // Storage arrays carry no reset; occupancy counters define what is valid.
    always_ff @(posedge clk) begin
        if (fifo_push_s) begin
            fifo_mem[wr_ptr_q] <= in_dat;
        end
        if (desc_push_s) begin
            desc_mem[desc_wr_q] <= new_desc_s;
        end
    end

    // Event and queue state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            open_q     <= 1'b0;
            bx_q       <= 3'd0;
            wcnt_q     <= 6'd0;
            trunc_q    <= 1'b0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            desc_wr_q  <= '0;
            desc_rd_q  <= '0;
            desc_cnt_q <= '0;
        end else begin
            open_q     <= open_d;
            bx_q       <= bx_d;
            wcnt_q     <= wcnt_d;
            trunc_q    <= trunc_d;
            overflow_q <= overflow_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            desc_wr_q  <= desc_wr_d;
            desc_rd_q  <= desc_rd_d;
            desc_cnt_q <= desc_cnt_d;
        end
    end

    // Frame FSM; the state names the word currently presented on the link.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            out_dat_q   <= '0;
            out_kind_q  <= KIND_IDLE;
            out_valid_q <= 1'b0;
            remain_q    <= 6'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (desc_cnt_q != '0) begin
                        out_dat_q   <= hdr_word(head_s.bx, head_s.cnt);
                        out_kind_q  <= KIND_HDR;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_HEADER;
                    end
                end
                ST_HEADER: begin
                    if (xfer_s) begin
                        if (head_s.cnt != 6'd0) begin
                            out_dat_q  <= fifo_mem[rd_ptr_q];
                            out_kind_q <= KIND_DATA;
                            remain_q   <= head_s.cnt - 6'd1;
                            state_q    <= ST_DATA;
                        end else begin
                            out_dat_q  <= trl_word(head_s.trunc, head_s.cnt);
                            out_kind_q <= KIND_TRL;
                            state_q    <= ST_TRAILER;
                        end
                    end
                end
                ST_DATA: begin
                    if (xfer_s) begin
                        if (remain_q != 6'd0) begin
                            out_dat_q <= fifo_mem[rd_ptr_q];
                            remain_q  <= remain_q - 6'd1;
                        end else begin
                            out_dat_q  <= trl_word(head_s.trunc, head_s.cnt);
                            out_kind_q <= KIND_TRL;
                            state_q    <= ST_TRAILER;
                        end
                    end
                end
                ST_TRAILER: begin
                    if (xfer_s) begin
                        // Another descriptor behind the head: start its header with no gap.
                        if (desc_cnt_q > {{DESC_AW{1'b0}}, 1'b1}) begin
                            out_dat_q  <= hdr_word(next_s.bx, next_s.cnt);
                            out_kind_q <= KIND_HDR;
                            state_q    <= ST_HEADER;
                        end else begin
                            out_dat_q   <= '0;
                            out_kind_q  <= KIND_IDLE;
                            out_valid_q <= 1'b0;
                            state_q     <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    out_dat_q   <= '0;
                    out_kind_q  <= KIND_IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_dat   = out_dat_q;
    assign out_kind  = out_kind_q;
    assign out_valid = out_valid_q;
    assign overflow  = overflow_q;

endmodule
